xray_pass_sequencer: RTL and testbench

Frame-level controller for the Main pixel datapath (select/value/threshold/in_byte → out_byte). It streams every pixel of a stored X-ray frame through the datapath once per enabled operation. It holds `dp_select`, `dp_value` and `dp_threshold` stable for the whole pass and writes results back in place, so passes chain without testbench stepping. It sits between the frame buffer (synchronous RAM, 1-cycle read) and Main.

---
 rtl/xray_pass_sequencer_if.sv | 35 +++
 rtl/xray_pass_sequencer.sv | 164 ++++++++++++++++
 tb/tb_xray_pass_sequencer.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/xray_pass_sequencer_if.sv
// Frame-buffer and pixel-datapath bundle for the X-ray pass sequencer.
// Signals: read port (rd_en/rd_addr/rd_data), Main operands and pixel
// (dp_select/dp_value/dp_threshold/dp_in_byte/dp_out_byte), and write
// port (wr_en/wr_addr/wr_data). master = sequencer, slave = RAM/Main.
interface xray_pass_sequencer_if #(
    parameter int ADDR_W = 17
);
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic [1:0]        dp_select;
    logic [7:0]        dp_value;
    logic [7:0]        dp_threshold;
    logic [7:0]        dp_in_byte;
    logic [7:0]        dp_out_byte;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;

    modport master (
        output rd_en, rd_addr,
        input  rd_data,
        output dp_select, dp_value, dp_threshold, dp_in_byte,
        input  dp_out_byte,
        output wr_en, wr_addr, wr_data
    );

    modport slave (
        input  rd_en, rd_addr,
        output rd_data,
        input  dp_select, dp_value, dp_threshold, dp_in_byte,
        output dp_out_byte,
        input  wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/xray_pass_sequencer.sv
// Streams a stored frame through the Main pixel datapath once per
// enabled pass, writing results back in place.
// Ports: clk, rst (async, active-high); start/abort/pass_mask/value_in/
// threshold_in job controls; busy/pass_done/done/aborted status;
// bus = frame-buffer read/write ports plus Main operands and pixel.
module xray_pass_sequencer #(
    parameter int NPIX     = 97792,
    parameter int ADDR_W   = 17,
    parameter int PIPE_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [3:0] pass_mask,
    input  logic [7:0] value_in,
    input  logic [7:0] threshold_in,
    output logic       busy,
    output logic       pass_done,
    output logic       done,
    output logic       aborted,
    xray_pass_sequencer_if.master bus
);
    // Depth of the read-to-write line: RAM read cycle plus Main latency.
    localparam int D   = 1 + PIPE_LAT;
    localparam int DCW = $clog2(D);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NPIX - 1);
    localparam logic [DCW-1:0]    D_END = DCW'(D - 1);
    localparam logic [DCW-1:0]    D_PRE = DCW'(D - 2);

    typedef enum logic [2:0] {
        IDLE, SEL, STREAM, DRAIN, FIN
    } state_t;

    state_t            state;
    logic [3:0]        mask_q;
    logic [ADDR_W-1:0] cnt;
    logic [DCW-1:0]    dcnt;
    logic              ab_q;
    logic [1:0]        sel_q;
    logic [7:0]        val_q;
    logic [7:0]        thr_q;
    logic [1:0]        k;

    logic              vld_q [D];
    logic [ADDR_W-1:0] la_q  [D];

    // Lowest remaining pass; several bits may be set, so order matters.
    always_comb begin
        k = 2'd0;
        priority case (1'b1)
            mask_q[0]: k = 2'd0;
            mask_q[1]: k = 2'd1;
            mask_q[2]: k = 2'd2;
            mask_q[3]: k = 2'd3;
            default:   k = 2'd0;
        endcase
    end

    // Abort cancels the read of the very cycle it is seen in.
    assign bus.rd_en        = (state == STREAM) && !abort;
    assign bus.rd_addr      = cnt;
    assign bus.dp_select    = sel_q;
    assign bus.dp_value     = val_q;
    assign bus.dp_threshold = thr_q;
    assign bus.dp_in_byte   = bus.rd_data;
    assign bus.wr_data      = bus.dp_out_byte;
    assign bus.wr_en        = vld_q[D-1];
    assign bus.wr_addr      = la_q[D-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            mask_q    <= '0;
            cnt       <= '0;
            dcnt      <= '0;
            ab_q      <= 1'b0;
            sel_q     <= '0;
            val_q     <= '0;
            thr_q     <= '0;
            busy      <= 1'b0;
            pass_done <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
        end else begin
            pass_done <= 1'b0;
            done      <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        mask_q  <= pass_mask;
                        val_q   <= value_in;
                        thr_q   <= threshold_in;
                        aborted <= 1'b0;
                        ab_q    <= 1'b0;
                        busy    <= 1'b1;
                        state   <= SEL;
                    end
                end
                SEL: begin
                    if (mask_q != 4'd0) begin
                        sel_q     <= k;
                        mask_q[k] <= 1'b0;
                        cnt       <= '0;
                        state     <= STREAM;
                    end else begin
                        done    <= 1'b1;
                        aborted <= ab_q;
                        state   <= FIN;
                    end
                end
                STREAM: begin
                    if (abort) begin
                        ab_q  <= 1'b1;
                        dcnt  <= '0;
                        state <= DRAIN;
                    end else if (cnt == LAST) begin
                        dcnt  <= '0;
                        state <= DRAIN;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (dcnt == D_END) begin
                        if (ab_q) begin
                            done    <= 1'b1;
                            aborted <= 1'b1;
                            state   <= FIN;
                        end else begin
                            state <= SEL;
                        end
                    end else begin
                        dcnt      <= dcnt + 1'b1;
                        // Lands in the last drain cycle with the last write.
                        pass_done <= (dcnt == D_PRE);
                    end
                end
                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Each issued read travels D cycles to become its own write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < D; i++) begin
                vld_q[i] <= 1'b0;
                la_q[i]  <= '0;
            end
        end else begin
            vld_q[0] <= bus.rd_en;
            la_q[0]  <= cnt;
            for (int i = 1; i < D; i++) begin
                vld_q[i] <= vld_q[i-1];
                la_q[i]  <= la_q[i-1];
            end
        end
    end
endmodule

// File: tb/tb_xray_pass_sequencer.sv
// Scoreboard bench: two sequencers (8 px / lat 1 and 5 px / lat 3)
// with RAM and Main models; expected reads, writes and events queued.
module tb_xray_pass_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       start_a = 1'b0, start_b = 1'b0;
    logic       abort_a = 1'b0, abort_b = 1'b0;
    logic [3:0] mask = '0;
    logic [7:0] val = '0, thr = '0;
    logic       busy_a, pd_a, dn_a, ab_a;
    logic       busy_b, pd_b, dn_b, ab_b;
    logic       load = 1'b0;
    logic [7:0] img [2][8];
    logic [7:0] mem_a [8];
    logic [7:0] mem_b [8];
    logic [7:0] pipe_b [2];

    xray_pass_sequencer_if #(.ADDR_W(17)) bus_a ();
    xray_pass_sequencer_if #(.ADDR_W(17)) bus_b ();

    xray_pass_sequencer #(.NPIX(8), .ADDR_W(17), .PIPE_LAT(1)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort_a),
        .pass_mask(mask), .value_in(val), .threshold_in(thr),
        .busy(busy_a), .pass_done(pd_a), .done(dn_a), .aborted(ab_a),
        .bus(bus_a)
    );

    xray_pass_sequencer #(.NPIX(5), .ADDR_W(17), .PIPE_LAT(3)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort_b),
        .pass_mask(mask), .value_in(val), .threshold_in(thr),
        .busy(busy_b), .pass_done(pd_b), .done(dn_b), .aborted(ab_b),
        .bus(bus_b)
    );

    function automatic logic [7:0] f(logic [1:0] s, logic [7:0] v,
                                     logic [7:0] t, logic [7:0] x);
        int r;
        case (s)
            2'd0: begin r = int'(x) + int'(v); if (r > 255) r = 255; end
            2'd1: begin r = int'(x) - int'(v); if (r < 0) r = 0; end
            2'd2: r = (x >= t) ? 255 : 0;
            default: r = 255 - int'(x);
        endcase
        return 8'(r);
    endfunction

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 8; i++) begin
                mem_a[i] <= img[0][i];
                mem_b[i] <= img[1][i];
            end
        end else begin
            if (bus_a.wr_en) mem_a[bus_a.wr_addr[2:0]] <= bus_a.wr_data;
            if (bus_b.wr_en) mem_b[bus_b.wr_addr[2:0]] <= bus_b.wr_data;
        end
        if (bus_a.rd_en) bus_a.rd_data <= mem_a[bus_a.rd_addr[2:0]];
        if (bus_b.rd_en) bus_b.rd_data <= mem_b[bus_b.rd_addr[2:0]];
        bus_a.dp_out_byte <= f(bus_a.dp_select, bus_a.dp_value,
                               bus_a.dp_threshold, bus_a.dp_in_byte);
        pipe_b[0] <= f(bus_b.dp_select, bus_b.dp_value,
                       bus_b.dp_threshold, bus_b.dp_in_byte);
        pipe_b[1] <= pipe_b[0];
        bus_b.dp_out_byte <= pipe_b[1];
    end

    typedef struct { int d; int cyc; int addr; } rd_t;
    typedef struct { int d; int cyc; int addr; int data; int sel; } wr_t;
    typedef struct { int d; int cyc; bit is_done; bit ab; } ev_t;
    rd_t rdq[$];
    wr_t wrq[$];
    ev_t evq[$];

    int errors = 0;
    int checks = 0;
    int busy_cnt [2];
    bit ign = 1'b0;
    int model [2][8];

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic ev(int d, bit is_done, logic ab);
        ev_t e;
        if (evq.size() == 0) begin
            chk("ev_extra", cyc, -1);
            return;
        end
        e = evq.pop_front();
        chk("ev_dut", d, e.d);
        chk("ev_cyc", cyc, e.cyc);
        chk("ev_kind", int'(is_done), int'(e.is_done));
        if (is_done) chk("aborted", int'(ab), int'(e.ab));
    endtask

    task automatic mon(int d, logic re, int ra, logic we, int wa, int wd,
                       int sel, logic bz, logic pd, logic dn, logic ab);
        rd_t r;
        wr_t w;
        if (ign || rst) return;
        if (bz) busy_cnt[d]++;
        if (re) begin
            if (rdq.size() == 0) chk("rd_extra", ra, -1);
            else begin
                r = rdq.pop_front();
                chk("rd_dut", d, r.d);
                chk("rd_cyc", cyc, r.cyc);
                chk("rd_addr", ra, r.addr);
            end
        end
        if (we) begin
            if (wrq.size() == 0) chk("wr_extra", wa, -1);
            else begin
                w = wrq.pop_front();
                chk("wr_dut", d, w.d);
                chk("wr_cyc", cyc, w.cyc);
                chk("wr_addr", wa, w.addr);
                chk("wr_data", wd, w.data);
                chk("wr_sel", sel, w.sel);
            end
        end
        if (pd) ev(d, 1'b0, ab);
        if (dn) ev(d, 1'b1, ab);
    endtask

    always @(negedge clk) begin
        mon(0, bus_a.rd_en, int'(bus_a.rd_addr), bus_a.wr_en,
            int'(bus_a.wr_addr), int'(bus_a.wr_data),
            int'(bus_a.dp_select), busy_a, pd_a, dn_a, ab_a);
        mon(1, bus_b.rd_en, int'(bus_b.rd_addr), bus_b.wr_en,
            int'(bus_b.wr_addr), int'(bus_b.wr_data),
            int'(bus_b.dp_select), busy_b, pd_b, dn_b, ab_b);
    end

    task automatic set_img(int d, int v0, int v1, int v2, int v3,
                           int v4, int v5, int v6, int v7);
        int v [8];
        v = '{v0, v1, v2, v3, v4, v5, v6, v7};
        for (int i = 0; i < 8; i++) begin
            img[d][i] = 8'(v[i]);
            model[d][i] = v[i];
        end
    endtask

    task automatic do_load();
        @(posedge clk); #1 load = 1'b1;
        @(posedge clk); #1 load = 1'b0;
    endtask

    task automatic job(int d, logic [3:0] m, int v, int t,
                       int abort_at, bit spur);
        int n, dl, p, cs, np, base, nr, done_cyc;
        bit ab;
        logic [7:0] w;
        n = d ? 5 : 8;
        dl = d ? 4 : 2;
        p = n + 1 + dl;
        np = 0;
        ab = 1'b0;
        @(posedge clk); #1;
        cs = cyc;
        mask = m; val = 8'(v); thr = 8'(t);
        if (d == 1) start_b = 1'b1; else start_a = 1'b1;
        busy_cnt[d] = 0;
        for (int k = 0; k < 4; k++) begin
            if (m[k] && !ab) begin
                base = cs + np * p;
                nr = (abort_at >= 0) ? abort_at : n;
                for (int i = 0; i < nr; i++) begin
                    rdq.push_back('{d, base + 2 + i, i});
                    w = f(2'(k), 8'(v), 8'(t), 8'(model[d][i]));
                    wrq.push_back('{d, base + 2 + i + dl, i, int'(w), k});
                    model[d][i] = int'(w);
                end
                if (abort_at >= 0) begin
                    ab = 1'b1;
                    evq.push_back('{d, base + 2 + abort_at + dl, 1'b0, 1'b0});
                end else begin
                    evq.push_back('{d, base + p, 1'b0, 1'b0});
                end
                np++;
            end
        end
        done_cyc = ab ? cs + 3 + abort_at + dl : cs + np * p + 2;
        evq.push_back('{d, done_cyc, 1'b1, ab});
        for (int c = 0; c < 4 * p + 20 && evq.size() != 0; c++) begin
            @(posedge clk); #1;
            start_a = 1'b0;
            start_b = 1'b0;
            abort_a = (d == 0) && (abort_at >= 0) && (cyc == cs + 2 + abort_at);
            abort_b = (d == 1) && (abort_at >= 0) && (cyc == cs + 2 + abort_at);
            if (spur && cyc == cs + 4) begin
                mask = 4'hF;
                val = 8'hFF;
                if (d == 1) start_b = 1'b1; else start_a = 1'b1;
            end
        end
        @(posedge clk); #1;
        start_a = 1'b0; start_b = 1'b0;
        abort_a = 1'b0; abort_b = 1'b0;
        chk("ev_left", evq.size(), 0);
        chk("rd_left", rdq.size(), 0);
        chk("wr_left", wrq.size(), 0);
        chk("busy_cycles", busy_cnt[d], done_cyc - cs);
        for (int i = 0; i < n; i++) begin
            if (d == 1) chk("mem_b", int'(mem_b[i]), model[1][i]);
            else chk("mem_a", int'(mem_a[i]), model[0][i]);
        end
        rdq.delete(); wrq.delete(); evq.delete();
    endtask

    initial begin
        #1;
        chk("rst_busy_a", int'(busy_a), 0);
        chk("rst_rd_en_a", int'(bus_a.rd_en), 0);
        chk("rst_wr_en_b", int'(bus_b.wr_en), 0);
        chk("rst_sel_a", int'(bus_a.dp_select), 0);
        chk("rst_done_b", int'(dn_b), 0);
        @(posedge clk); #1 rst = 1'b0;

        set_img(0, 0, 1, 2, 3, 4, 5, 6, 7);
        set_img(1, 0, 64, 128, 192, 255, 0, 0, 0);
        do_load();
        job(0, 4'b0100, 60, 160, -1, 1'b0);

        set_img(0, 10, 50, 90, 130, 170, 210, 250, 30);
        do_load();
        job(0, 4'b1011, 100, 160, -1, 1'b0);

        job(0, 4'b0000, 1, 1, -1, 1'b0);

        set_img(0, 200, 100, 30, 160, 128, 5, 9, 77);
        do_load();
        job(0, 4'b0011, 20, 128, 3, 1'b0);

        ign = 1'b1;
        @(posedge clk); #1;
        mask = 4'b0100; val = 8'd33; thr = 8'd44; start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_rd_en", int'(bus_a.rd_en), 0);
        chk("arst_rd_addr", int'(bus_a.rd_addr), 0);
        chk("arst_wr_en", int'(bus_a.wr_en), 0);
        chk("arst_wr_addr", int'(bus_a.wr_addr), 0);
        chk("arst_sel", int'(bus_a.dp_select), 0);
        chk("arst_value", int'(bus_a.dp_value), 0);
        chk("arst_thr", int'(bus_a.dp_threshold), 0);
        chk("arst_busy", int'(busy_a), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        ign = 1'b0;
        set_img(0, 3, 140, 250, 99, 160, 161, 159, 0);
        do_load();
        job(0, 4'b0101, 7, 160, -1, 1'b0);

        job(1, 4'b0110, 40, 100, -1, 1'b1);
        job(1, 4'b0001, 5, 0, 4, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
